// File: rtl/imem_pkg.sv
// Types and constants shared by the instruction store and its loader.
package imem_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;
  localparam int IMEM_IW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

  // A load request is legal for 1..depth words.
  function automatic logic words_legal(input logic [IMEM_AW:0] n, input int depth);
    return (n != '0) && (32'(n) <= depth);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; flags the word on its 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_in,
  output logic               word_valid,
  output logic [IMEM_IW-1:0] word
);

  logic [1:0]         cnt_q, cnt_d;
  logic [IMEM_IW-1:0] asm_q, asm_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      asm_d = {byte_in, asm_q[IMEM_IW-1:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  assign word_valid = accept && !clear && (cnt_q == 2'd3);
  assign word       = {byte_in, asm_q[IMEM_IW-1:8]};

endmodule

// File: rtl/instr_mem_loader.sv
// Fills the instruction store from a byte stream and holds the CPU in reset until done.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready are both high.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   num_words,
  input  logic          byte_valid,
  input  logic [7:0]    byte_in,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold,
  output loader_state_e state_dbg
);

  loader_state_e state_q;
  logic [AW:0]   num_q;
  logic [AW:0]   word_cnt_q;
  logic          byte_ready_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          cpu_hold_q;

  logic          accept;
  logic          pack_clear;
  logic          word_valid;
  logic [31:0]   word;
  logic          start_ok;

  assign accept     = byte_valid && byte_ready_q;
  assign pack_clear = start && (state_q != LOAD);
  assign start_ok   = (num_words != '0) && (32'(num_words) <= DEPTH);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .accept     (accept),
    .byte_in    (byte_in),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      num_q        <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          mem_we_q <= 1'b0;
          if (start) begin
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            if (start_ok) begin
              state_q      <= LOAD;
              num_q        <= num_words;
              word_cnt_q   <= '0;
              mem_addr_q   <= '0;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
              error_q      <= 1'b0;
            end else begin
              state_q      <= ERR;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
            end
          end
        end
        LOAD: begin
          mem_we_q <= word_valid;
          if (word_valid) begin
            mem_wdata_q <= word;
            mem_addr_q  <= word_cnt_q[AW-1:0];
            word_cnt_q  <= word_cnt_q + (AW+1)'(1);
            // Stop taking bytes as soon as the final word is complete.
            if (word_cnt_q == num_q - (AW+1)'(1)) begin
              byte_ready_q <= 1'b0;
            end
          end
          // Counter already advanced past the last word while its write is on the port.
          if (mem_we_q && (word_cnt_q == num_q)) begin
            state_q      <= DONE;
            mem_we_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            cpu_hold_q   <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          mem_we_q     <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = cpu_hold_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: byte-stream model predicts every write and its cycle.
module tb_instr_mem_loader;
  import imem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [6:0]    num_words;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready;
  logic          mem_we;
  logic [5:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;
  loader_state_e state_dbg;

  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold),
    .state_dbg  (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          exp_cyc_q[$];
  logic [31:0] prog[64];

  always @(negedge clk) begin : monitor
    logic [31:0] d;
    logic [31:0] a;
    int          c;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", 32'd1, 32'd0);
      end else begin
        d = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        c = exp_cyc_q.pop_front();
        check_eq("we_data", mem_wdata, d);
        check_eq("we_addr", 32'(mem_addr), a);
        check_eq("we_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"},  32'(byte_ready), 32'd0);
    check_eq({tag, "_we"},     32'(mem_we),     32'd0);
    check_eq({tag, "_addr"},   32'(mem_addr),   32'd0);
    check_eq({tag, "_wdata"},  mem_wdata,       32'd0);
    check_eq({tag, "_busy"},   32'(busy),       32'd0);
    check_eq({tag, "_done"},   32'(done),       32'd0);
    check_eq({tag, "_error"},  32'(error),      32'd0);
    check_eq({tag, "_hold"},   32'(cpu_hold),   32'd1);
  endtask

  task automatic fill_random(input int from);
    for (int i = from; i < 64; i++) prog[i] = $urandom();
  endtask

  // Entered and left at a falling edge. abort_at >= 0 stops streaming after that many bytes.
  task automatic load(input int n, input int pct, input int mid_start_at, input int abort_at);
    int          acc;
    int          guard;
    int          t0;
    bit          v;
    bit          pulsed;
    logic [31:0] w;
    start     = 1'b1;
    num_words = 7'(n);
    @(negedge clk);
    start = 1'b0;
    if (n < 1 || n > 64) begin
      check_eq("ill_error", 32'(error),     32'd1);
      check_eq("ill_done",  32'(done),      32'd0);
      check_eq("ill_busy",  32'(busy),      32'd0);
      check_eq("ill_hold",  32'(cpu_hold),  32'd1);
      check_eq("ill_state", 32'(state_dbg), 32'(ERR));
      for (int i = 0; i < 3; i++) begin
        check_eq("ill_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b1;
        byte_in    = 8'($urandom_range(255));
        @(negedge clk);
      end
      byte_valid = 1'b0;
      check_eq("ill_hold_after", 32'(cpu_hold), 32'd1);
      return;
    end
    check_eq("ld_busy",  32'(busy),     32'd1);
    check_eq("ld_done",  32'(done),     32'd0);
    check_eq("ld_error", 32'(error),    32'd0);
    check_eq("ld_hold",  32'(cpu_hold), 32'd1);
    t0     = cyc;
    acc    = 0;
    guard  = 0;
    pulsed = 0;
    while (acc < 4 * n && guard < 4 * n * 30 + 50) begin
      if (abort_at >= 0 && acc == abort_at) break;
      start = 1'b0;
      if (mid_start_at >= 0 && acc == mid_start_at && !pulsed) begin
        start     = 1'b1;
        num_words = 7'd1;
        pulsed    = 1;
      end
      v = ($urandom_range(99) < pct);
      w = prog[acc / 4];
      check_eq("ready_in_load", 32'(byte_ready), 32'd1);
      byte_valid = v;
      byte_in    = v ? w[8 * (acc % 4) +: 8] : 8'($urandom_range(255));
      if (v) begin
        acc++;
        if (acc % 4 == 0) begin
          exp_q.push_back(prog[acc / 4 - 1]);
          exp_addr_q.push_back(32'(acc / 4 - 1));
          exp_cyc_q.push_back(cyc + 1);
        end
      end
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (abort_at >= 0) return;
    if (acc < 4 * n) begin
      check_eq("stream_timeout", 32'(acc), 32'(4 * n));
      return;
    end
    check_eq("last_ready", 32'(byte_ready), 32'd0);
    check_eq("last_done",  32'(done),       32'd0);
    check_eq("last_busy",  32'(busy),       32'd1);
    @(negedge clk);
    check_eq("end_done",  32'(done),       32'd1);
    check_eq("end_hold",  32'(cpu_hold),   32'd0);
    check_eq("end_busy",  32'(busy),       32'd0);
    check_eq("end_error", 32'(error),      32'd0);
    check_eq("end_ready", 32'(byte_ready), 32'd0);
    check_eq("end_state", 32'(state_dbg),  32'(DONE));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    if (pct >= 100) check_eq("load_cycles", 32'(cyc - t0), 32'(4 * n + 1));
    // Bytes after completion must be ignored.
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    @(negedge clk);
    byte_valid = 1'b0;
    check_eq("post_ready", 32'(byte_ready), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_in    = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_hold", 32'(cpu_hold), 32'd1);

    // single known word
    prog[0] = 32'h0000_2083;
    load(1, 100, -1, -1);

    // three known words, ragged valid
    prog[0] = 32'h0000_2083;
    prog[1] = 32'h0040_2103;
    prog[2] = 32'h0080_2183;
    load(3, 50, -1, -1);

    // illegal counts, then recovery
    load(0, 100, -1, -1);
    load(65, 100, -1, -1);
    load($urandom_range(66, 127), 100, -1, -1);
    fill_random(0);
    load(2, 70, -1, -1);

    // full depth, back to back, with a start pulse mid-load
    fill_random(0);
    load(64, 100, 37, -1);

    // reset mid-load, then a fresh load
    fill_random(0);
    load(2, 100, -1, 6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("midrst");
    check_eq("midrst_sb", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    prog[0] = $urandom();
    load(1, 60, -1, -1);

    // random lengths and valid densities
    for (int k = 0; k < 4; k++) begin
      fill_random(0);
      load($urandom_range(1, 8), $urandom_range(40, 100), -1, -1);
    end

    repeat (3) @(negedge clk);
    check_eq("final_sb", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
